float_add_stream: RTL and testbench
===================================

Name: float_add_stream

Overview:
- Multi-lane, fully pipelined IEEE-style floating-point adder/subtractor with a valid/ready stream interface and backpressure.
- Performs alignment, add/sub, normalization, round-to-nearest-even and packing internally, so its output is a final rounded float rather than unrounded fraction plus trailing bits.
- Sits between accumulator/dot-product datapaths and downstream FIFOs in the float arithmetic library.
- All lanes share one handshake and advance in lockstep.

Parameters:
- EXP, 8, exponent field width (≥3)
- FRAC, 23, fraction field width (≥2)
- LANES, 4, number of independent adders sharing the handshake
- W (derived, 1+EXP+FRAC), per-lane float word width; not overridable

Ports:
- clock  input  1  rising-edge clock
- resetN  input  1  asynchronous active-low reset
- inValid  input  1  input beat valid
- inReady  output  1  block accepts beat this cycle
- inA  input  LANES*W  operand A, lane i at bits [i*W +: W], {sign, exponent, fraction}
- inB  input  LANES*W  operand B, same packing
- subtract  input  LANES  per-lane: 1 computes A−B, 0 computes A+B
- outValid  output  1  result beat valid
- outReady  input  1  downstream accepts result
- out  output  LANES*W  rounded results, same packing
- outIsNan  output  LANES  lane result is NaN
- outInexact  output  LANES  rounding discarded nonzero bits
- outOverflow  output  LANES  finite inputs rounded to infinity

Behaviour:
- Reset (resetN low, asynchronous): every stage valid bit clears; outValid=0; out, outIsNan, outInexact, outOverflow all 0. Reset mid-operation discards all in-flight beats. inReady=1 once reset is released.
- Pipeline is four stages: S1 classify, sort by magnitude, align the smaller operand, compute the sticky OR of shifted-out bits; S2 add/sub in FRAC+5 bits (carry, hidden, fraction, guard, round, sticky); S3 normalize (carry right-shift folds into sticky; CLZ left-shift for subtract, clamped at exponent 1); S4 round-nearest-even and pack.
- Global enable is en = !outValid || outReady. inReady = en. All stages advance only when en=1, and bubbles are not collapsed.
- A beat is accepted when inValid && inReady. Latency is exactly 4 cycles with no stall. Throughput is 1 beat/cycle.
- While outValid=1 && outReady=0, out and all flags hold stable, and no stage changes.
- Rounding uses guard=g, round=r, sticky=s, and LSB of kept fraction=l. Round up iff g && (r || s || l). outInexact = g||r||s.
- A round carry renormalizes by incrementing the exponent. If the exponent reaches all-ones, the result is ±inf with sign of the result, and outOverflow=1, outInexact=1.
- Special cases:
  - NaN input, or inf−inf with effective subtraction → canonical NaN: sign 0, exponent all-ones, fraction MSB 1, rest 0. outIsNan=1, other flags 0.
  - inf ± finite → that inf with its (subtract-corrected) sign. Flags 0.
  - Exact zero result from effective subtraction → +0.
  - (−0)+(−0) → −0.
  - (+0)+(−0) → +0.
- A denormal sum that carries into the hidden bit becomes normal with exponent 1.
- Lanes are independent. Flags are per lane.

Optional Feature:
- Macro FLOAT_ADD_STREAM_DENORMAL_EN.
- When defined: full denormal support on inputs and outputs, with gradual underflow.
- When undefined: any input with exponent 0 is treated as signed zero (sign kept). Any result whose normalized exponent would be ≤0 is flushed to signed zero, with outInexact=1 if the pre-flush value was nonzero. The S3 normalize clamp logic and denormal alignment correction are removed.

Test Plan:
- Default params, lane0: 0x3F800000+0x3F800000 → 0x40000000 at exactly cycle+4; lane1 0x3F800000−0x3F800000 → 0x00000000 with sign 0; flags 0.
- Tie cases: 0x3F800000+0x33800000 → 0x3F800000 with outInexact=1; 0x3F800001+0x33800000 → 0x3F800002 with outInexact=1.
- Overflow and specials: 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 with outOverflow=1; 0x7F800000−0x7F800000 → 0x7FC00000 with outIsNan=1; 0x7F800000+0x3F800000 → 0x7F800000.
- Backpressure: outReady=0 for 10 cycles with inValid=1 and distinct data each cycle → exactly 4 beats accepted, out stable throughout; release → beats emerge in order, none lost or duplicated.
- Reset: assert resetN low mid-stream with 3 beats in flight → outValid=0 and outputs 0 immediately (asynchronous); no stale beat appears after release.
- Denormal: 0x00000001+0x00000001 → 0x00000002 with macro defined; → 0x00000000 with macro undefined. 0x00800000−0x00000001 → 0x007FFFFF with macro defined.

Source files
------------

// File: rtl/float_add_stream.sv
// float_add_stream: LANES-wide, 4-stage pipelined float add/sub with round-nearest-even and valid/ready backpressure.
// Optional macro FLOAT_ADD_STREAM_DENORMAL_EN enables gradual underflow; otherwise denormals flush to signed zero.
module float_add_stream #(
  parameter int unsigned EXP   = 8,
  parameter int unsigned FRAC  = 23,
  parameter int unsigned LANES = 4
) (
  input  logic                              clock,
  input  logic                              resetN,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic [LANES*(1+EXP+FRAC)-1:0]     inA,
  input  logic [LANES*(1+EXP+FRAC)-1:0]     inB,
  input  logic [LANES-1:0]                  subtract,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [LANES*(1+EXP+FRAC)-1:0]     out,
  output logic [LANES-1:0]                  outIsNan,
  output logic [LANES-1:0]                  outInexact,
  output logic [LANES-1:0]                  outOverflow
);
  localparam int unsigned W   = 1 + EXP + FRAC;
  localparam int unsigned M   = FRAC + 1;
  localparam int unsigned SW  = FRAC + 5;
  localparam int unsigned EW  = EXP + 2;
  localparam int unsigned AW  = 2 * (M + 2);
  localparam int unsigned LZW = $clog2(SW + 1);
  localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP{1'b1}}};

  logic en, v1, v2, v3;

  assign en      = !outValid || outReady;
  assign inReady = en;

  // Shared lockstep valid chain; bubbles travel with the data.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      outValid <= 1'b0;
    end else if (en) begin
      v1       <= inValid;
      v2       <= v1;
      v3       <= v2;
      outValid <= v3;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [W-1:0]  a, b;
    logic          sA, sB, aNan, bNan, aInf, bInf, aBig, stickyC;
    logic [EW-1:0] eA, eB, d;
    logic [M-1:0]  mA, mB, mSmall;
    logic [AW-1:0] alignWide;
    logic [M+1:0]  alignC;

    logic          s1Nan, s1Inf, s1InfSign, s1Sign, s1Sub, s1Sticky;
    logic [EW-1:0] s1Exp;
    logic [M-1:0]  s1Mant;
    logic [M+1:0]  s1Small;

    logic [SW-1:0] sumC;
    logic          s2Nan, s2Inf, s2InfSign, s2Sign, s2Sub;
    logic [EW-1:0] s2Exp;
    logic [SW-1:0] s2Sum;

    logic [LZW-1:0] lz;
    logic [EW-1:0]  sh, expN;
    logic [SW-2:0]  sumN;
    logic           zeroC, flushC;
    logic           s3Nan, s3Inf, s3InfSign, s3Sign, s3Zero, s3Flush, s3G, s3R, s3S;
    logic [EW-1:0]  s3Exp;
    logic [M-1:0]   s3Mant;

    logic          up, nanC, inxC, ovfC;
    logic [M:0]    mantR;
    logic [EW-1:0] expR;
    logic [W-1:0]  resC, resQ;
    logic          nanQ, inxQ, ovfQ;

    // S1: classify, order by magnitude, align the smaller operand.
    always_comb begin
      a    = inA[i*W +: W];
      b    = inB[i*W +: W];
      sA   = a[W-1];
      sB   = b[W-1] ^ subtract[i];
      aNan = (&a[W-2 -: EXP]) && (|a[FRAC-1:0]);
      bNan = (&b[W-2 -: EXP]) && (|b[FRAC-1:0]);
      aInf = (&a[W-2 -: EXP]) && !(|a[FRAC-1:0]);
      bInf = (&b[W-2 -: EXP]) && !(|b[FRAC-1:0]);
`ifdef FLOAT_ADD_STREAM_DENORMAL_EN
      eA = (a[W-2 -: EXP] == '0) ? EW'(1) : EW'(a[W-2 -: EXP]);
      eB = (b[W-2 -: EXP] == '0) ? EW'(1) : EW'(b[W-2 -: EXP]);
      mA = {|a[W-2 -: EXP], a[FRAC-1:0]};
      mB = {|b[W-2 -: EXP], b[FRAC-1:0]};
`else
      eA = EW'(a[W-2 -: EXP]);
      eB = EW'(b[W-2 -: EXP]);
      mA = (a[W-2 -: EXP] == '0) ? M'(0) : {1'b1, a[FRAC-1:0]};
      mB = (b[W-2 -: EXP] == '0) ? M'(0) : {1'b1, b[FRAC-1:0]};
`endif
      aBig      = {eA, mA} >= {eB, mB};
      d         = aBig ? (eA - eB) : (eB - eA);
      mSmall    = aBig ? mB : mA;
      alignWide = '0;
      alignC    = '0;
      stickyC   = 1'b0;
      if (d >= EW'(M + 2)) begin
        stickyC = |mSmall;
      end else begin
        alignWide = {mSmall, {(M+4){1'b0}}} >> d;
        alignC    = alignWide[AW-1 -: M+2];
        stickyC   = |alignWide[M+1:0];
      end
    end

    always_ff @(posedge clock) begin
      if (en) begin
        s1Nan     <= aNan || bNan || (aInf && bInf && (sA != sB));
        s1Inf     <= aInf || bInf;
        s1InfSign <= aInf ? sA : sB;
        s1Sign    <= aBig ? sA : sB;
        s1Sub     <= sA != sB;
        s1Exp     <= aBig ? eA : eB;
        s1Mant    <= aBig ? mA : mB;
        s1Small   <= alignC;
        s1Sticky  <= stickyC;
      end
    end

    // S2: {carry, hidden, fraction, guard, round, sticky}; big >= small so no sign flip.
    assign sumC = s1Sub ? ({1'b0, s1Mant, 3'b000} - {1'b0, s1Small, s1Sticky})
                        : ({1'b0, s1Mant, 3'b000} + {1'b0, s1Small, s1Sticky});

    always_ff @(posedge clock) begin
      if (en) begin
        s2Nan     <= s1Nan;
        s2Inf     <= s1Inf;
        s2InfSign <= s1InfSign;
        s2Sign    <= s1Sign;
        s2Sub     <= s1Sub;
        s2Exp     <= s1Exp;
        s2Sum     <= sumC;
      end
    end

    // S3: normalize; a carry folds the dropped bit into sticky, cancellation shifts left.
    always_comb begin
      lz = '0;
      for (int j = 0; j < int'(SW) - 1; j++) begin
        if (s2Sum[j]) lz = LZW'(int'(SW) - 2 - j);
      end
      zeroC  = (s2Sum == '0);
      flushC = 1'b0;
      sh     = '0;
      if (s2Sum[SW-1]) begin
        sumN = {s2Sum[SW-1:2], s2Sum[1] | s2Sum[0]};
        expN = s2Exp + EW'(1);
      end else begin
`ifdef FLOAT_ADD_STREAM_DENORMAL_EN
        sh = (EW'(lz) > (s2Exp - EW'(1))) ? (s2Exp - EW'(1)) : EW'(lz);
`else
        sh     = EW'(lz);
        flushC = !zeroC && (EW'(lz) >= s2Exp);
`endif
        sumN = (SW-1)'(s2Sum << sh);
        expN = s2Exp - sh;
      end
    end

    always_ff @(posedge clock) begin
      if (en) begin
        s3Nan     <= s2Nan;
        s3Inf     <= s2Inf;
        s3InfSign <= s2InfSign;
        s3Sign    <= (zeroC && s2Sub) ? 1'b0 : s2Sign;
        s3Zero    <= zeroC;
        s3Flush   <= flushC;
        s3Exp     <= expN;
        s3Mant    <= sumN[SW-2:3];
        s3G       <= sumN[2];
        s3R       <= sumN[1];
        s3S       <= sumN[0];
      end
    end

    // S4: round-nearest-even, renormalize on round carry, then pack with special-case priority.
    always_comb begin
      up    = s3G && (s3R || s3S || s3Mant[0]);
      mantR = {1'b0, s3Mant} + (M+1)'(up);
      expR  = s3Exp;
      if (mantR[M]) begin
        mantR = mantR >> 1;
        expR  = s3Exp + EW'(1);
      end
      resC = {s3Sign, (mantR[M-1] ? expR[EXP-1:0] : EXP'(0)), mantR[FRAC-1:0]};
      nanC = 1'b0;
      inxC = s3G || s3R || s3S;
      ovfC = 1'b0;
      if (s3Nan) begin
        resC = {1'b0, {EXP{1'b1}}, 1'b1, (FRAC-1)'(0)};
        nanC = 1'b1;
        inxC = 1'b0;
      end else if (s3Inf) begin
        resC = {s3InfSign, {EXP{1'b1}}, FRAC'(0)};
        inxC = 1'b0;
      end else if (s3Zero) begin
        resC = {s3Sign, (W-1)'(0)};
        inxC = 1'b0;
      end else if (s3Flush) begin
        resC = {s3Sign, (W-1)'(0)};
        inxC = 1'b1;
      end else if (expR >= EXP_MAX) begin
        resC = {s3Sign, {EXP{1'b1}}, FRAC'(0)};
        ovfC = 1'b1;
        inxC = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        resQ <= '0;
        nanQ <= 1'b0;
        inxQ <= 1'b0;
        ovfQ <= 1'b0;
      end else if (en && v3) begin
        resQ <= resC;
        nanQ <= nanC;
        inxQ <= inxC;
        ovfQ <= ovfC;
      end
    end

    assign out[i*W +: W] = resQ;
    assign outIsNan[i]   = nanQ;
    assign outInexact[i] = inxQ;
    assign outOverflow[i] = ovfQ;
  end

endmodule

// File: tb/tb_float_add_stream.sv
// Scoreboard bench for float_add_stream: directed float vectors, backpressure hold, async reset flush.
module tb_float_add_stream;
  localparam int unsigned EXP   = 8;
  localparam int unsigned FRAC  = 23;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 1 + EXP + FRAC;
  localparam int unsigned BW    = LANES * W;

  logic            clock = 1'b0;
  logic            resetN;
  logic            inValid, inReady, outValid, outReady;
  logic [BW-1:0]   inA, inB, out;
  logic [LANES-1:0] subtract, outIsNan, outInexact, outOverflow;

  float_add_stream #(.EXP(EXP), .FRAC(FRAC), .LANES(LANES)) dut (
    .clock(clock), .resetN(resetN),
    .inValid(inValid), .inReady(inReady),
    .inA(inA), .inB(inB), .subtract(subtract),
    .outValid(outValid), .outReady(outReady),
    .out(out), .outIsNan(outIsNan), .outInexact(outInexact), .outOverflow(outOverflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [BW-1:0]    res;
    logic [LANES-1:0] nan, inx, ovf;
    int               issue;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cycleCnt = 0;
  int beatNo = 0;
  bit held = 1'b0;
  logic [BW+3*LANES-1:0] heldVal;

  logic [31:0] fTab [0:15];

  always @(posedge clock) cycleCnt++;

  function automatic logic [BW-1:0] pk(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every transferred beat; checks hold stability while stalled.
  always @(negedge clock) begin
    if (!resetN) begin
      held = 1'b0;
    end else if (outValid && outReady) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_beat: got out=%h with empty scoreboard", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int l = 0; l < int'(LANES); l++) begin
          compared++;
          if (out[l*W +: W] !== e.res[l*W +: W] || outIsNan[l] !== e.nan[l] ||
              outInexact[l] !== e.inx[l] || outOverflow[l] !== e.ovf[l]) begin
            mismatched++;
            $display("FAIL beat%0d lane%0d: got out=%h nan=%b inx=%b ovf=%b, expected out=%h nan=%b inx=%b ovf=%b",
                     beatNo, l, out[l*W +: W], outIsNan[l], outInexact[l], outOverflow[l],
                     e.res[l*W +: W], e.nan[l], e.inx[l], e.ovf[l]);
          end
        end
        if (e.lat) begin
          compared++;
          if (cycleCnt != e.issue + 4) begin
            mismatched++;
            $display("FAIL latency beat%0d: got %0d cycles, expected 4", beatNo, cycleCnt - e.issue);
          end
        end
      end
      beatNo++;
      held = 1'b0;
    end else if (outValid) begin
      if (held) begin
        compared++;
        if ({out, outIsNan, outInexact, outOverflow} !== heldVal) begin
          mismatched++;
          $display("FAIL stall_hold: got %h, expected %h", {out, outIsNan, outInexact, outOverflow}, heldVal);
        end
      end else begin
        heldVal = {out, outIsNan, outInexact, outOverflow};
        held = 1'b1;
      end
    end
  end

  task automatic sendBeat(input logic [BW-1:0] a, b, input logic [LANES-1:0] sub,
                          input logic [BW-1:0] res, input logic [LANES-1:0] nan, inx, ovf,
                          input bit lat);
    exp_t e;
    int tries;
    tries = 0;
    inValid = 1'b1; inA = a; inB = b; subtract = sub;
    forever begin
      @(negedge clock);
      if (inReady) break;
      tries++;
      if (tries > 100) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout: inReady stayed 0, expected 1");
        inValid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    e.res = res; e.nan = nan; e.inx = inx; e.ovf = ovf; e.issue = cycleCnt; e.lat = lat;
    sb.push_back(e);
    @(posedge clock); #1;
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d beats outstanding, expected 0", sb.size());
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    fTab[0]  = 32'h00000000; fTab[1]  = 32'h3F800000; fTab[2]  = 32'h40000000; fTab[3]  = 32'h40400000;
    fTab[4]  = 32'h40800000; fTab[5]  = 32'h40A00000; fTab[6]  = 32'h40C00000; fTab[7]  = 32'h40E00000;
    fTab[8]  = 32'h41000000; fTab[9]  = 32'h41100000; fTab[10] = 32'h41200000; fTab[11] = 32'h41300000;
    fTab[12] = 32'h41400000; fTab[13] = 32'h41500000; fTab[14] = 32'h41600000; fTab[15] = 32'h41700000;

    resetN = 1'b0; inValid = 1'b0; inA = '0; inB = '0; subtract = '0; outReady = 1'b1;
    #12;
    chk("reset_outValid", BW'(outValid), BW'(0));
    chk("reset_out", out, '0);
    chk("reset_flags", BW'({outIsNan, outInexact, outOverflow}), BW'(0));
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    #1 chk("release_inReady", BW'(inReady), BW'(1));

    // Basic add/sub and tie-to-even.
    sendBeat(pk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001),
             pk(32'h3F800000, 32'h3F800000, 32'h33800000, 32'h33800000), 4'b0010,
             pk(32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800002), 4'b0000, 4'b1100, 4'b0000, 1'b1);
    // Overflow, inf-inf, inf+finite, (-0)+(-0).
    sendBeat(pk(32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h80000000),
             pk(32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h80000000), 4'b0010,
             pk(32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h80000000), 4'b0010, 4'b0001, 4'b0001, 1'b1);
    // Zeros and denormal handling.
`ifdef FLOAT_ADD_STREAM_DENORMAL_EN
    sendBeat(pk(32'h00000000, 32'h00000001, 32'h00800000, 32'h00800001),
             pk(32'h80000000, 32'h00000001, 32'h00000001, 32'h00800000), 4'b1100,
             pk(32'h00000000, 32'h00000002, 32'h007FFFFF, 32'h00000001), 4'b0000, 4'b0000, 4'b0000, 1'b1);
`else
    sendBeat(pk(32'h00000000, 32'h00000001, 32'h00800000, 32'h00800001),
             pk(32'h80000000, 32'h00000001, 32'h00000001, 32'h00800000), 4'b1100,
             pk(32'h00000000, 32'h00000000, 32'h00800000, 32'h00000000), 4'b0000, 4'b1000, 4'b0000, 1'b1);
`endif
    // Negative results, -inf-(+inf), NaN input.
    sendBeat(pk(32'hC0000000, 32'h3F800000, 32'hFF800000, 32'hFFFFFFFF),
             pk(32'h3F800000, 32'h40000000, 32'h7F800000, 32'h3F800000), 4'b0110,
             pk(32'hBF800000, 32'hBF800000, 32'hFF800000, 32'h7FC00000), 4'b1000, 4'b0000, 4'b0000, 1'b1);
    // Exact carry overflow, round carry, cancellation normalize, tie on subtract.
    sendBeat(pk(32'h7F000000, 32'h3FFFFFFF, 32'h3F800000, 32'h3F800000),
             pk(32'h7F000000, 32'h34000000, 32'h33800000, 32'h33000000), 4'b1100,
             pk(32'h7F800000, 32'h40000000, 32'h3F7FFFFF, 32'h3F800000), 4'b0000, 4'b1001, 4'b0001, 1'b1);
    drain();

    // Backpressure: only the four pipeline slots may fill while the sink stalls.
    outReady = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      inValid = 1'b1;
      inA = pk(fTab[k+1], fTab[k+1], fTab[k+1], fTab[k+1]);
      inB = pk(fTab[1], fTab[2], fTab[3], fTab[4]);
      subtract = '0;
      @(negedge clock);
      if (inReady) begin
        exp_t e;
        e.res = pk(fTab[k+2], fTab[k+3], fTab[k+4], fTab[k+5]);
        e.nan = '0; e.inx = '0; e.ovf = '0; e.issue = cycleCnt; e.lat = 1'b0;
        sb.push_back(e);
        acc++;
      end
      @(posedge clock); #1;
    end
    inValid = 1'b0;
    chk("stall_accepted", BW'(acc), BW'(4));
    outReady = 1'b1;
    drain();

    // Asynchronous reset with beats in flight.
    sendBeat(pk(fTab[1], fTab[2], fTab[3], fTab[4]), pk(fTab[1], fTab[1], fTab[1], fTab[1]), 4'b0000,
             pk(fTab[2], fTab[3], fTab[4], fTab[5]), 4'b0000, 4'b0000, 4'b0000, 1'b0);
    sendBeat(pk(fTab[5], fTab[6], fTab[7], fTab[8]), pk(fTab[1], fTab[1], fTab[1], fTab[1]), 4'b0000,
             pk(fTab[6], fTab[7], fTab[8], fTab[9]), 4'b0000, 4'b0000, 4'b0000, 1'b0);
    sendBeat(pk(fTab[9], fTab[10], fTab[11], fTab[12]), pk(fTab[1], fTab[1], fTab[1], fTab[1]), 4'b0000,
             pk(fTab[10], fTab[11], fTab[12], fTab[13]), 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(posedge clock); #1;
    chk("pre_reset_outValid", BW'(outValid), BW'(1));
    #1 resetN = 1'b0;
    #1;
    chk("async_reset_outValid", BW'(outValid), BW'(0));
    chk("async_reset_out", out, '0);
    chk("async_reset_flags", BW'({outIsNan, outInexact, outOverflow}), BW'(0));
    sb.delete();
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("post_reset_outValid", BW'(outValid), BW'(0));
    chk("post_reset_inReady", BW'(inReady), BW'(1));

    // Function recovers after reset.
    sendBeat(pk(32'h7F000000, 32'h3FFFFFFF, 32'h3F800000, 32'h3F800000),
             pk(32'h7F000000, 32'h34000000, 32'h33800000, 32'h33000000), 4'b1100,
             pk(32'h7F800000, 32'h40000000, 32'h3F7FFFFF, 32'h3F800000), 4'b0000, 4'b1001, 4'b0001, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
